// File: rtl/fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : fft_bitrev_reorder
// Purpose  : Output-side reorder buffer for the parallel FFT pipeline. Takes
//            frames of COUNT beats x NUM lanes in bit-reversed index order and
//            re-emits each frame in natural index order. Two register banks
//            are used as ping-pong buffers so frames can arrive back-to-back.
// Ports    : clk, rst (async, active-high)
//            din_i/din_q   [NUM] signed samples in, bit-reversed order
//            valid_in      beat valid, a frame is COUNT consecutive beats
//            dout_i/dout_q [NUM] signed samples out, natural order (0 if idle)
//            valid_out     output beat valid
//            sof_out       high with output beat 0 of each frame
//            frame_err     (FFT_REORDER_ERR_EN) one-cycle pulse on partial frame
//            err_cnt       (FFT_REORDER_ERR_EN) saturating partial-frame count
// Options  : define FFT_REORDER_ERR_EN to add frame_err / err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module fft_bitrev_reorder #(
  parameter int WIDTH = 13,
  parameter int NUM   = 16,
  parameter int DATA  = 64,
  parameter int COUNT = DATA / NUM,
  parameter int LOGN  = $clog2(DATA)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] din_i [0:NUM-1],
  input  logic signed [WIDTH-1:0] din_q [0:NUM-1],
  input  logic                    valid_in,
  output logic signed [WIDTH-1:0] dout_i [0:NUM-1],
  output logic signed [WIDTH-1:0] dout_q [0:NUM-1],
  output logic                    valid_out,
  output logic                    sof_out
`ifdef FFT_REORDER_ERR_EN
  ,
  output logic                    frame_err,
  output logic [7:0]              err_cnt
`endif
);

  localparam int            c_CW      = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [c_CW-1:0] c_LAST  = c_CW'(COUNT - 1);
  localparam logic [0:0]    c_ST_IDLE = 1'b0;
  localparam logic [0:0]    c_ST_READ = 1'b1;

  function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] x);
    logic [LOGN-1:0] r;
    for (int k = 0; k < LOGN; k++) r[k] = x[LOGN-1-k];
    return r;
  endfunction

  // Ping-pong storage; index [bank][position]
  logic signed [WIDTH-1:0] mem_i_q [0:1][0:DATA-1];
  logic signed [WIDTH-1:0] mem_q_q [0:1][0:DATA-1];

  logic [c_CW-1:0]         wr_cnt_q, wr_cnt_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [0:0]              state_q, state_d;
  logic [c_CW-1:0]         rd_cnt_q, rd_cnt_d;
  logic                    valid_out_q, valid_out_d;
  logic                    sof_out_q, sof_out_d;
  logic signed [WIDTH-1:0] dout_i_q [0:NUM-1];
  logic signed [WIDTH-1:0] dout_i_d [0:NUM-1];
  logic signed [WIDTH-1:0] dout_q_q [0:NUM-1];
  logic signed [WIDTH-1:0] dout_q_d [0:NUM-1];
  logic                    frame_done;

  always_comb begin
    frame_done  = valid_in && (wr_cnt_q == c_LAST);
    wr_cnt_d    = '0;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;

    // A drop of valid_in mid-frame discards the partial frame.
    if (valid_in && !frame_done) wr_cnt_d = wr_cnt_q + 1'b1;
    if (frame_done) wr_bank_d = ~wr_bank_q;

    case (state_q)
      c_ST_READ: begin
        if (rd_cnt_q == c_LAST) begin
          state_d  = c_ST_IDLE;
          rd_cnt_d = '0;
        end else begin
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
      end
      default: begin
        rd_cnt_d = '0;
      end
    endcase

    // A completed frame always (re)starts a readout of the bank just filled;
    // this also covers the back-to-back case on the last read beat.
    if (frame_done) begin
      state_d   = c_ST_READ;
      rd_cnt_d  = '0;
      rd_bank_d = wr_bank_q;
    end

    valid_out_d = (state_q == c_ST_READ);
    sof_out_d   = (state_q == c_ST_READ) && (rd_cnt_q == '0);

    for (int l = 0; l < NUM; l++) begin
      logic [LOGN-1:0] pos;
      pos = bitrev(LOGN'(int'(rd_cnt_q) * NUM + l));
      if (state_q == c_ST_READ) begin
        dout_i_d[l] = mem_i_q[rd_bank_q][pos];
        dout_q_d[l] = mem_q_q[rd_bank_q][pos];
      end else begin
        dout_i_d[l] = '0;
        dout_q_d[l] = '0;
      end
    end
  end

  // Sample storage is written in place and never needs clearing.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int l = 0; l < NUM; l++) begin
        mem_i_q[wr_bank_q][LOGN'(int'(wr_cnt_q) * NUM + l)] <= din_i[l];
        mem_q_q[wr_bank_q][LOGN'(int'(wr_cnt_q) * NUM + l)] <= din_q[l];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      state_q     <= c_ST_IDLE;
      rd_cnt_q    <= '0;
      valid_out_q <= 1'b0;
      sof_out_q   <= 1'b0;
      for (int l = 0; l < NUM; l++) begin
        dout_i_q[l] <= '0;
        dout_q_q[l] <= '0;
      end
    end else begin
      wr_cnt_q    <= wr_cnt_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      valid_out_q <= valid_out_d;
      sof_out_q   <= sof_out_d;
      for (int l = 0; l < NUM; l++) begin
        dout_i_q[l] <= dout_i_d[l];
        dout_q_q[l] <= dout_q_d[l];
      end
    end
  end

  assign dout_i    = dout_i_q;
  assign dout_q    = dout_q_q;
  assign valid_out = valid_out_q;
  assign sof_out   = sof_out_q;

`ifdef FFT_REORDER_ERR_EN
  logic       frame_err_q, frame_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    frame_err_d = !valid_in && (wr_cnt_q != '0);
    err_cnt_d   = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_err = frame_err_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fft_bitrev_reorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bitrev_reorder
// Purpose  : Self-checking bench for fft_bitrev_reorder. A reference model
//            records each complete input frame and schedules the expected
//            natural-order output beats by cycle number.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bitrev_reorder;

  localparam int WIDTH = 13;
  localparam int NUM   = 16;
  localparam int DATA  = 64;
  localparam int COUNT = DATA / NUM;
  localparam int LOGN  = 6;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    valid_in = 1'b0;
  logic signed [WIDTH-1:0] din_i  [0:NUM-1];
  logic signed [WIDTH-1:0] din_q  [0:NUM-1];
  logic signed [WIDTH-1:0] dout_i [0:NUM-1];
  logic signed [WIDTH-1:0] dout_q [0:NUM-1];
  logic                    valid_out;
  logic                    sof_out;
`ifdef FFT_REORDER_ERR_EN
  logic                    frame_err;
  logic [7:0]              err_cnt;
`endif

  fft_bitrev_reorder #(
    .WIDTH(WIDTH), .NUM(NUM), .DATA(DATA)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din_i    (din_i),
    .din_q    (din_q),
    .valid_in (valid_in),
    .dout_i   (dout_i),
    .dout_q   (dout_q),
    .valid_out(valid_out),
    .sof_out  (sof_out)
`ifdef FFT_REORDER_ERR_EN
    ,
    .frame_err(frame_err),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  int                      m_wr = 0;
  int                      m_err_cnt = 0;
  bit                      m_err_now = 0;
  logic signed [WIDTH-1:0] fr_i [DATA];
  logic signed [WIDTH-1:0] fr_q [DATA];
  bit                      exp_v  [int];
  bit                      exp_s  [int];
  logic signed [WIDTH-1:0] exp_di [int];
  logic signed [WIDTH-1:0] exp_dq [int];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rev(input int p);
    int r = 0;
    for (int k = 0; k < LOGN; k++) r = (r << 1) | ((p >> k) & 1);
    return r;
  endfunction

  task automatic check_outputs();
    bit ev, es;
    ev = exp_v.exists(cyc) ? exp_v[cyc] : 1'b0;
    es = exp_s.exists(cyc) ? exp_s[cyc] : 1'b0;
    check_val($sformatf("valid_out@%0d", cyc), {31'd0, valid_out}, {31'd0, ev});
    check_val($sformatf("sof_out@%0d", cyc), {31'd0, sof_out}, {31'd0, es});
    for (int l = 0; l < NUM; l++) begin
      logic signed [WIDTH-1:0] ei, eq;
      int k;
      k  = cyc * NUM + l;
      ei = exp_di.exists(k) ? exp_di[k] : '0;
      eq = exp_dq.exists(k) ? exp_dq[k] : '0;
      check_val($sformatf("dout_i@%0d.l%0d", cyc, l), dout_i[l], ei);
      check_val($sformatf("dout_q@%0d.l%0d", cyc, l), dout_q[l], eq);
    end
`ifdef FFT_REORDER_ERR_EN
    check_val($sformatf("frame_err@%0d", cyc), {31'd0, frame_err}, {31'd0, m_err_now});
    check_val($sformatf("err_cnt@%0d", cyc), {24'd0, err_cnt}, m_err_cnt);
`endif
  endtask

  // One clock: model reacts to the inputs seen at this edge, then outputs
  // are compared 1 time unit later.
  task automatic tick();
    @(posedge clk);
    cyc++;
    m_err_now = 0;
    if (rst) begin
      m_wr = 0;
      m_err_cnt = 0;
    end else if (valid_in) begin
      for (int l = 0; l < NUM; l++) begin
        fr_i[m_wr*NUM + l] = din_i[l];
        fr_q[m_wr*NUM + l] = din_q[l];
      end
      if (m_wr == COUNT - 1) begin
        for (int ob = 0; ob < COUNT; ob++) begin
          exp_v[cyc + 1 + ob] = 1'b1;
          exp_s[cyc + 1 + ob] = (ob == 0);
          for (int l = 0; l < NUM; l++) begin
            exp_di[(cyc + 1 + ob)*NUM + l] = fr_i[rev(ob*NUM + l)];
            exp_dq[(cyc + 1 + ob)*NUM + l] = fr_q[rev(ob*NUM + l)];
          end
        end
        m_wr = 0;
      end else begin
        m_wr++;
      end
    end else begin
      if (m_wr != 0) begin
        m_err_now = 1;
        if (m_err_cnt < 255) m_err_cnt++;
      end
      m_wr = 0;
    end
    #1;
    check_outputs();
  endtask

  // mode 0: p / -p ; mode 1: 64f+p / -(64f+p) ; mode 2: random ; 3: extremes
  task automatic drive_beat(input int mode, input int f, input int b);
    for (int l = 0; l < NUM; l++) begin
      int p;
      p = b*NUM + l;
      case (mode)
        0: begin din_i[l] = WIDTH'(p); din_q[l] = WIDTH'(-p); end
        1: begin din_i[l] = WIDTH'(64*f + p); din_q[l] = WIDTH'(-(64*f + p)); end
        2: begin din_i[l] = WIDTH'($urandom); din_q[l] = WIDTH'($urandom); end
        default: begin
          din_i[l] = ($urandom_range(0, 1) == 1) ? 13'sd4095 : -13'sd4096;
          din_q[l] = ($urandom_range(0, 1) == 1) ? 13'sd4095 : -13'sd4096;
        end
      endcase
    end
    valid_in = 1'b1;
  endtask

  task automatic send_frame(input int mode, input int f, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(mode, f, b);
      tick();
    end
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    for (int l = 0; l < NUM; l++) begin
      din_i[l] = WIDTH'($urandom);
      din_q[l] = WIDTH'($urandom);
    end
    repeat (n) tick();
  endtask

  initial begin
    for (int l = 0; l < NUM; l++) begin
      din_i[l] = '0;
      din_q[l] = '0;
    end
    // Reset state
    repeat (2) tick();
    rst = 1'b0;
    idle(2);

    // Single directed frame
    send_frame(0, 0, COUNT);
    idle(1);
    check_val("beat0_sof", {31'd0, sof_out}, 32'd1);
    check_val("beat0_l0", dout_i[0], 32'd0);
    check_val("beat0_l1", dout_i[1], 32'd32);
    check_val("beat0_l2", dout_i[2], 32'd16);
    check_val("beat0_l3", dout_i[3], 32'd48);
    check_val("beat0_q1", dout_q[1], -32);
    idle(1);
    check_val("beat1_l0", dout_i[0], 32'd2);
    check_val("beat1_sof", {31'd0, sof_out}, 32'd0);
    idle(COUNT);

    // Three back-to-back frames
    for (int f = 0; f < 3; f++) send_frame(1, f, COUNT);
    idle(COUNT + 1);

    // Partial frame, then a full one
    send_frame(2, 0, 2);
    idle(1);
    send_frame(2, 0, COUNT);
    idle(COUNT + 1);

    // Gap of 3 idle cycles between frames
    send_frame(2, 0, COUNT);
    idle(3);
    send_frame(2, 0, COUNT);
    idle(COUNT + 1);

    // Reset during output beat 1
    send_frame(2, 0, COUNT);
    idle(2);
    #2 rst = 1'b1;
    #1;
    exp_v.delete(); exp_s.delete(); exp_di.delete(); exp_dq.delete();
    m_wr = 0; m_err_cnt = 0; m_err_now = 0;
    check_outputs();
    idle(2);
    rst = 1'b0;
    idle(1);
    send_frame(2, 0, COUNT);
    idle(COUNT + 1);

    // Extreme values
    send_frame(3, 0, COUNT);
    send_frame(3, 0, COUNT);
    idle(COUNT + 1);

    // Random mix of frames, partial frames and gaps
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        send_frame(2, 0, $urandom_range(1, COUNT - 1));
        idle($urandom_range(1, 3));
      end else begin
        send_frame(2, 0, COUNT);
        if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      end
    end
    idle(COUNT + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
